snowball_mem_responder: RTL and testbench

Memory-side responder for the snowball cache's MCU memory port. It accepts single-word writes and two-word read bursts on `mem_*` in the `MCU_CLK` domain and serves them from an on-chip block-RAM array. It sits in the slot normally taken by the external DRAM controller, so the cache/MCU path can run stand-alone on the FPGA. All timing below is fixed by the cache's `read_counter`/`capture_data` capture logic.

---
 rtl/snowball_mem_responder.sv | 132 +++++++++++++
 tb/tb_snowball_mem_responder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/snowball_mem_responder.sv
// Block-RAM stand-in for the DRAM controller on the snowball cache MCU port.
// Optional protocol checker: define SNOWBALL_MEMRSP_PROTOCOL_CHECK_EN.
module snowball_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int ACK_LAT = 2
) (
  input  logic        MCU_CLK,
  input  logic        RST_SYS,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [3:0]  mem_we_array,
  input  logic        mem_do_act,
  input  logic [31:0] mem_dataintomem,
  output logic        mem_ack,
  output logic [31:0] mem_datafrommem,
  output logic        protocol_err
);

  localparam int DATA_W = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_BEAT0 = 3'd4;
  localparam logic [2:0] S_BEAT1 = 3'd5;

  logic [2:0]        state;
  logic [3:0]        lat_cnt;
  logic [1:0]        gap_cnt;

  logic [ADDR_W-1:0] addr_p0;
  logic              we_p0;
  logic [3:0]        be_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic [DATA_W-1:0] mem_array [2**ADDR_W];
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rdata_p1;

  logic              unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:ADDR_W];

  // Control FSM; the gap is stretched so the first beat lands on ack+4,
  // where the cache capture logic expects it.
  always_ff @(posedge MCU_CLK) begin
    if (RST_SYS) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_do_act) begin
            if (ACK_LAT == 1) begin
              state <= S_ACK;
            end else begin
              state   <= S_WAIT;
              lat_cnt <= 4'(ACK_LAT - 1);
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt == 4'd1) state <= S_ACK;
          lat_cnt <= lat_cnt - 4'd1;
        end
        S_ACK: begin
          if (we_p0) begin
            state <= S_IDLE;
          end else begin
            state   <= S_GAP;
            gap_cnt <= 2'd2;
          end
        end
        S_GAP: begin
          if (gap_cnt == 2'd0) state <= S_BEAT0;
          else gap_cnt <= gap_cnt - 2'd1;
        end
        S_BEAT0: state <= S_BEAT1;
        S_BEAT1: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: request capture at acceptance
  always_ff @(posedge MCU_CLK) begin
    if (state == S_IDLE && mem_do_act) begin
      addr_p0  <= mem_addr[ADDR_W-1:0];
      we_p0    <= mem_we;
      be_p0    <= mem_we_array;
      wdata_p0 <= mem_dataintomem;
    end
  end

  assign rd_en   = (state == S_GAP && gap_cnt == 2'd0) || (state == S_BEAT0);
  assign rd_addr = (state == S_BEAT0) ? {addr_p0[ADDR_W-1:1], ~addr_p0[0]} : addr_p0;

  // Stage p1: array write in ACK, synchronous read feeding the beats
  always_ff @(posedge MCU_CLK) begin
    if (state == S_ACK && we_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p0[i]) mem_array[addr_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
      end
    end
    if (rd_en) rdata_p1 <= mem_array[rd_addr];
  end

  assign mem_ack         = (state == S_ACK);
  assign mem_datafrommem = (state == S_BEAT0 || state == S_BEAT1) ? rdata_p1 : '0;

`ifdef SNOWBALL_MEMRSP_PROTOCOL_CHECK_EN
  logic ack_d;

  always_ff @(posedge MCU_CLK) begin
    if (RST_SYS) begin
      ack_d        <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      ack_d <= (state == S_ACK);
      if ((state == S_WAIT && !mem_do_act) ||
          (ack_d && mem_do_act) ||
          ((state == S_GAP || state == S_BEAT0 || state == S_BEAT1) && mem_do_act))
        protocol_err <= 1'b1;
    end
  end
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_snowball_mem_responder.sv
// Directed bench for snowball_mem_responder: one instance at ACK_LAT=2, one at ACK_LAT=1.
module tb_snowball_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din;
  logic        we;
  logic [3:0]  be;
  logic        act0, act1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] dout0, dout1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snowball_mem_responder #(.ADDR_W(10), .ACK_LAT(2)) dut (
    .MCU_CLK(clk), .RST_SYS(rst), .mem_addr(addr), .mem_we(we),
    .mem_we_array(be), .mem_do_act(act0), .mem_dataintomem(din),
    .mem_ack(ack0), .mem_datafrommem(dout0), .protocol_err(err0)
  );

  snowball_mem_responder #(.ADDR_W(10), .ACK_LAT(1)) dut1 (
    .MCU_CLK(clk), .RST_SYS(rst), .mem_addr(addr), .mem_we(we),
    .mem_we_array(be), .mem_do_act(act1), .mem_dataintomem(din),
    .mem_ack(ack1), .mem_datafrommem(dout1), .protocol_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One transaction, entered and left at posedge+1. Cycle c=0 is the acceptance
  // cycle; ack expected at c=lat, beats at lat+4 / lat+5. hold_extra keeps the
  // request up that many cycles past ack; rst_cyc (>=0) pulses reset in that cycle.
  task automatic xact(input int d, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] wd,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input int hold_extra, input int rst_cyc);
    int lat;
    int n;
    lat  = (d == 0) ? 2 : 1;
    n    = w ? lat + 1 : lat + 6;
    addr = a; we = w; be = b; din = wd;
    if (d == 0) act0 = 1'b1; else act1 = 1'b1;
    for (int c = 0; c <= n; c++) begin
      logic [31:0] ed;
      logic        ag;
      logic [31:0] dg;
      @(negedge clk);
      ag = (d == 0) ? ack0 : ack1;
      dg = (d == 0) ? dout0 : dout1;
      ed = '0;
      if (!w && (rst_cyc < 0 || c <= rst_cyc)) begin
        if (c == lat + 4) ed = e0;
        if (c == lat + 5) ed = e1;
      end
      chk("ack", {31'b0, ag}, {31'b0, (c == lat)});
      chk("rdata", dg, ed);
      @(posedge clk); #1;
      if (c == lat + hold_extra) begin
        act0 = 1'b0; act1 = 1'b0; we = 1'b0;
      end
      if (rst_cyc >= 0) begin
        if (c + 1 == rst_cyc) rst = 1'b1;
        else if (c == rst_cyc) rst = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] perr_exp;
    rst = 1'b1; act0 = 1'b0; act1 = 1'b0; we = 1'b0;
    addr = '0; be = '0; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    chk("rst_dout0", dout0, 32'd0);
    chk("rst_err0", {31'b0, err0}, 32'd0);
    chk("rst_ack1", {31'b0, ack1}, 32'd0);
    chk("rst_dout1", dout1, 32'd0);
    chk("rst_err1", {31'b0, err1}, 32'd0);
    @(posedge clk); #1;

    // Preload and masked write
    xact(0, 1'b1, 32'h10, 4'hF,    32'h11223344, '0, '0, 0, -1);
    xact(0, 1'b1, 32'h10, 4'b1100, 32'hDEADBEEF, '0, '0, 0, -1);
    xact(0, 1'b1, 32'h11, 4'hF,    32'hCAFEF00D, '0, '0, 0, -1);
    // Even and odd bursts
    xact(0, 1'b0, 32'h10, 4'h0, '0, 32'hDEAD3344, 32'hCAFEF00D, 0, -1);
    xact(0, 1'b0, 32'h11, 4'h0, '0, 32'hCAFEF00D, 32'hDEAD3344, 0, -1);
    chk("perr_clean", {31'b0, err0}, 32'd0);

    // Latency 1 with aliased upper address bits
    xact(1, 1'b1, 32'h00000011, 4'hF, 32'h01234567, '0, '0, 0, -1);
    xact(1, 1'b1, 32'hC0000010, 4'hF, 32'h5A5A5A5A, '0, '0, 0, -1);
    xact(1, 1'b0, 32'h00000010, 4'h0, '0, 32'h5A5A5A5A, 32'h01234567, 0, -1);
    chk("perr1_clean", {31'b0, err1}, 32'd0);

    // Request held through k+1
`ifdef SNOWBALL_MEMRSP_PROTOCOL_CHECK_EN
    perr_exp = 32'd1;
`else
    perr_exp = 32'd0;
`endif
    xact(0, 1'b0, 32'h10, 4'h0, '0, 32'hDEAD3344, 32'hCAFEF00D, 1, -1);
    chk("perr_set", {31'b0, err0}, perr_exp);
    repeat (5) @(posedge clk);
    #1;
    chk("perr_sticky", {31'b0, err0}, perr_exp);

    // Reset at k+4 of a burst, then a clean burst
    xact(0, 1'b0, 32'h11, 4'h0, '0, 32'hCAFEF00D, 32'hDEAD3344, 0, 6);
    chk("perr_cleared", {31'b0, err0}, 32'd0);
    xact(0, 1'b0, 32'h10, 4'h0, '0, 32'hDEAD3344, 32'hCAFEF00D, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
